load_store_unit: RTL and testbench

Parametrised multi-cycle memory-access unit for the accumulator datapath. It executes LOAD X, LOADI X (indirect), and STORE X through internal MAR/MBR registers. It talks to memory over a req/ready handshake with variable latency, and guards each access with a timeout. It sits between the control unit (start/op/done) and the memory port, and drives the accumulator write-back.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/mem_wait_timer.sv | 35 +++
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and default widths for the load/store unit.
//   lsu_op_e    : operation codes presented on the op port
//   lsu_state_e : FSM state encoding, also exported for debug
package lsu_pkg;

  localparam int LSU_DATA_W  = 16;
  localparam int LSU_ADDR_W  = 12;
  localparam int LSU_TIMEOUT = 64;

  typedef enum logic [1:0] {
    OP_LOAD    = 2'd0,
    OP_STORE   = 2'd1,
    OP_LOADI   = 2'd2,
    OP_ILLEGAL = 2'd3
  } lsu_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_INDIR  = 3'd2,
    ST_XFER   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_FINISH = 3'd5
  } lsu_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Counts the cycles a memory access has been waiting for its ready.
//   clk, reset : clock, asynchronous active-high reset
//   clr_i      : hold the count at zero (no access in flight)
//   en_i       : access is waiting this cycle (req high, ready low)
//   expired_o  : this is the TIMEOUT-th waiting cycle; never set when TIMEOUT=0
module mem_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // The count holds the number of waiting cycles already elapsed, so the
  // TIMEOUT-th waiting cycle is the one where it equals TIMEOUT-1.
  assign expired_o = (TIMEOUT != 0) && en_i && (cnt_q == LAST);

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle LOAD / LOADI / STORE engine for the accumulator datapath.
// Accesses memory through MAR/MBR over a req/ready handshake, each access
// guarded by a wait timer. ADDR_W must not exceed DATA_W.
//   clk, reset           : clock, asynchronous active-high reset
//   start, op, addr_in   : command from the control unit (sampled in IDLE)
//   ac_in                : accumulator value written by STORE
//   busy, done, err      : status; done/err are one-cycle pulses
//   ac_out, ac_we        : accumulator write-back
//   mar, mbr             : internal registers for debug/display
//   mem_*                : memory port
//   dbg_state            : current FSM state
// Handshake: while mem_req is high, mem_addr/mem_we/mem_wdata are held
// stable; an access completes in the cycle mem_ready is high, and mem_req
// drops in the following cycle. mem_ready with mem_req low is ignored.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_W  = LSU_DATA_W,
  parameter int ADDR_W  = LSU_ADDR_W,
  parameter int TIMEOUT = LSU_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] ac_in,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] ac_out,
  output logic              ac_we,
  output logic [ADDR_W-1:0] mar,
  output logic [DATA_W-1:0] mbr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output lsu_state_e        dbg_state
);

  lsu_state_e        state_q;
  lsu_op_e           op_q;
  logic              ind_q;   // pointer already followed for this LOADI
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] mbr_q;
  logic [DATA_W-1:0] ac_q;
  logic              done_q;
  logic              err_q;
  logic              ac_we_q;

  logic in_access;
  logic tmo_expired;

  // Request is decoded straight from the state register, so it falls
  // together with the asynchronous reset of the state.
  assign in_access = (state_q == ST_FETCH) || (state_q == ST_WRITE);

  mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (!in_access),
    .en_i      (in_access && !mem_ready),
    .expired_o (tmo_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOAD;
      ind_q   <= 1'b0;
      mar_q   <= '0;
      mbr_q   <= '0;
      ac_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ac_we_q <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ac_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mar_q <= addr_in;
            op_q  <= lsu_op_e'(op);
            ind_q <= 1'b0;
            case (lsu_op_e'(op))
              OP_STORE: begin
                mbr_q   <= ac_in;
                state_q <= ST_WRITE;
              end
              OP_LOAD, OP_LOADI: state_q <= ST_FETCH;
              default: begin
                done_q <= 1'b1;
                err_q  <= 1'b1;
              end
            endcase
          end
        end
        ST_FETCH: begin
          // A ready in the expiring cycle still completes the access.
          if (mem_ready) begin
            mbr_q <= mem_rdata;
            if (op_q == OP_LOADI && !ind_q) state_q <= ST_INDIR;
            else                            state_q <= ST_XFER;
          end else if (tmo_expired) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_INDIR: begin
          // Pointer silently wraps to the address width.
          mar_q   <= mbr_q[ADDR_W-1:0];
          ind_q   <= 1'b1;
          state_q <= ST_FETCH;
        end
        ST_XFER: begin
          ac_q    <= mbr_q;
          ac_we_q <= 1'b1;
          done_q  <= 1'b1;
          state_q <= ST_IDLE;
        end
        ST_WRITE: begin
          if (mem_ready) begin
            done_q  <= 1'b1;
            state_q <= ST_FINISH;
          end else if (tmo_expired) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign ac_out    = ac_q;
  assign ac_we     = ac_we_q;
  assign mar       = mar_q;
  assign mbr       = mbr_q;
  assign mem_req   = in_access;
  assign mem_we    = (state_q == ST_WRITE);
  assign mem_addr  = mar_q;
  assign mem_wdata = mbr_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a variable-latency memory model.
// Expected completions and expected memory accesses are queued when each
// command is issued; two monitors pop and compare as the DUT produces them.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 12;
  localparam int TMO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT ----------------
  logic          start;
  logic [1:0]    op;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] ac_in;
  logic          busy, done, err, ac_we;
  logic [DW-1:0] ac_out, mbr, mem_wdata, mem_rdata;
  logic [AW-1:0] mar, mem_addr;
  logic          mem_req, mem_we, mem_ready;
  lsu_state_e    dbg_state;

  load_store_unit #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .addr_in   (addr_in),
    .ac_in     (ac_in),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .ac_out    (ac_out),
    .ac_we     (ac_we),
    .mar       (mar),
    .mbr       (mbr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic          err;
    logic          ac_we;
    logic [DW-1:0] ac;
    logic [AW-1:0] mar;
    logic [DW-1:0] mbr;
    int            lat;
    int            issue;
  } done_exp_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            len;
  } acc_exp_t;

  done_exp_t done_q[$];
  acc_exp_t  acc_q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [0:(1<<AW)-1];
  int wait_n = 0;
  int wcnt   = 0;

  // Responds a little after each rising edge, once mem_req has settled.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_req) begin
        if (wcnt >= wait_n) begin
          mem_ready = 1'b1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem[mem_addr];
          wcnt = 0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 16'hDEAD;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // ---------------- access monitor ----------------
  logic          in_acc = 1'b0;
  int            acc_len = 0;
  acc_exp_t      cur_acc;
  logic [AW-1:0] p_addr;
  logic          p_we;
  logic [DW-1:0] p_wdata;

  always @(negedge clk) begin
    if (mem_req) begin
      if (!in_acc) begin
        if (acc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req addr=0x%0h we=%0b", mem_addr, mem_we);
          cur_acc = '{we: 1'b0, addr: '0, wdata: '0, len: 0};
        end else begin
          cur_acc = acc_q.pop_front();
          check("acc_addr", 32'(mem_addr), 32'(cur_acc.addr));
          check("acc_we", 32'(mem_we), 32'(cur_acc.we));
          if (cur_acc.we) check("acc_wdata", 32'(mem_wdata), 32'(cur_acc.wdata));
        end
        in_acc  = 1'b1;
        acc_len = 1;
      end else begin
        acc_len++;
        check("hold_addr", 32'(mem_addr), 32'(p_addr));
        check("hold_we", 32'(mem_we), 32'(p_we));
        check("hold_wdata", 32'(mem_wdata), 32'(p_wdata));
      end
      p_addr  = mem_addr;
      p_we    = mem_we;
      p_wdata = mem_wdata;
    end else if (in_acc) begin
      check("acc_len", 32'(acc_len), 32'(cur_acc.len));
      in_acc = 1'b0;
    end
  end

  // ---------------- completion monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (done_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done err=%0b ac_we=%0b", err, ac_we);
        end else begin
          done_exp_t e;
          e = done_q.pop_front();
          check("done_err", 32'(err), 32'(e.err));
          check("done_ac_we", 32'(ac_we), 32'(e.ac_we));
          check("done_ac_out", 32'(ac_out), 32'(e.ac));
          check("done_mar", 32'(mar), 32'(e.mar));
          check("done_mbr", 32'(mbr), 32'(e.mbr));
          check("done_latency", 32'(cyc - e.issue + 1), 32'(e.lat));
        end
      end else if (err || ac_we) begin
        checks++;
        errors++;
        $display("FAIL pulse_without_done err=%0b ac_we=%0b", err, ac_we);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] o, input logic [AW-1:0] a, input logic [DW-1:0] acv,
                       input bit expect_done, input done_exp_t e);
    @(negedge clk);
    start   = 1'b1;
    op      = o;
    addr_in = a;
    ac_in   = acv;
    @(posedge clk);
    #1;
    start = 1'b0;
    e.issue = cyc;
    if (expect_done) done_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (done_q.size() != 0 && n < 60) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (done_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout pending=%0d expected=0", done_q.size());
      done_q.delete();
    end
  endtask

  function automatic done_exp_t mk(input logic e, input logic w, input logic [DW-1:0] acv,
                                   input logic [AW-1:0] m, input logic [DW-1:0] b, input int l);
    done_exp_t r;
    r = '{err: e, ac_we: w, ac: acv, mar: m, mbr: b, lat: l, issue: 0};
    return r;
  endfunction

  function automatic acc_exp_t acc(input logic w, input logic [AW-1:0] a,
                                   input logic [DW-1:0] d, input int l);
    acc_exp_t r;
    r = '{we: w, addr: a, wdata: d, len: l};
    return r;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    mem[12'h010] = 16'h1234;
    mem[12'h020] = 16'h0030;
    mem[12'h030] = 16'hBEEF;
    mem[12'h040] = 16'h0C3C;
    mem[12'h060] = 16'hA070;   // pointer above ADDR_W: wraps to 0x070
    mem[12'h070] = 16'h7777;

    start = 1'b0; op = 2'd0; addr_in = '0; ac_in = '0;
    reset = 1'b1;
    #3;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_ac_we", 32'(ac_we), 0);
    check("rst_ac_out", 32'(ac_out), 0);
    check("rst_mar", 32'(mar), 0);
    check("rst_mbr", 32'(mbr), 0);
    check("rst_mem_req", 32'(mem_req), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // LOAD 0x010, zero-wait
    wait_n = 0;
    acc_q.push_back(acc(1'b0, 12'h010, '0, 1));
    issue(2'd0, 12'h010, 16'h0000, 1'b1, mk(1'b0, 1'b1, 16'h1234, 12'h010, 16'h1234, 3));
    drain();

    // LOADI 0x020 -> 0x030
    acc_q.push_back(acc(1'b0, 12'h020, '0, 1));
    acc_q.push_back(acc(1'b0, 12'h030, '0, 1));
    issue(2'd2, 12'h020, 16'h0000, 1'b1, mk(1'b0, 1'b1, 16'hBEEF, 12'h030, 16'hBEEF, 5));
    drain();

    // STORE 0x0FF with three wait cycles; ready lands on the last allowed
    // cycle before timeout. A start during the access must be ignored.
    wait_n = 3;
    acc_q.push_back(acc(1'b1, 12'h0FF, 16'hA5A5, 4));
    issue(2'd1, 12'h0FF, 16'hA5A5, 1'b1, mk(1'b0, 1'b0, 16'hBEEF, 12'h0FF, 16'hA5A5, 5));
    @(negedge clk);
    start = 1'b1; op = 2'd0; addr_in = 12'h010;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();
    check("mem_0ff", 32'(mem[12'h0FF]), 32'h0000A5A5);

    // LOAD with memory never ready -> timeout after 4 request cycles
    wait_n = 100;
    acc_q.push_back(acc(1'b0, 12'h010, '0, 4));
    issue(2'd0, 12'h010, 16'h0000, 1'b1, mk(1'b1, 1'b0, 16'hBEEF, 12'h010, 16'hA5A5, 5));
    drain();

    // Illegal op, then a LOAD started in the done cycle
    wait_n = 0;
    acc_q.push_back(acc(1'b0, 12'h040, '0, 1));
    issue(2'd3, 12'h123, 16'h0000, 1'b1, mk(1'b1, 1'b0, 16'hBEEF, 12'h123, 16'hA5A5, 1));
    issue(2'd0, 12'h040, 16'h0000, 1'b1, mk(1'b0, 1'b1, 16'h0C3C, 12'h040, 16'h0C3C, 3));
    drain();

    // LOADI whose pointer exceeds the address width
    acc_q.push_back(acc(1'b0, 12'h060, '0, 1));
    acc_q.push_back(acc(1'b0, 12'h070, '0, 1));
    issue(2'd2, 12'h060, 16'h0000, 1'b1, mk(1'b0, 1'b1, 16'h7777, 12'h070, 16'h7777, 5));
    drain();

    // LOADI with two wait cycles per read: 5 + 2 + 2
    wait_n = 2;
    acc_q.push_back(acc(1'b0, 12'h020, '0, 3));
    acc_q.push_back(acc(1'b0, 12'h030, '0, 3));
    issue(2'd2, 12'h020, 16'h0000, 1'b1, mk(1'b0, 1'b1, 16'hBEEF, 12'h030, 16'hBEEF, 9));
    drain();

    // Reset in the middle of a waiting FETCH
    wait_n = 100;
    acc_q.push_back(acc(1'b0, 12'h010, '0, 2));
    issue(2'd0, 12'h010, 16'h0000, 1'b0, mk(1'b0, 1'b0, '0, '0, '0, 0));
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_mem_req", 32'(mem_req), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_ac_out", 32'(ac_out), 0);
    check("abort_mar", 32'(mar), 0);
    check("abort_mbr", 32'(mbr), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_n = 0;
    acc_q.push_back(acc(1'b0, 12'h010, '0, 1));
    issue(2'd0, 12'h010, 16'h0000, 1'b1, mk(1'b0, 1'b1, 16'h1234, 12'h010, 16'h1234, 3));
    drain();

    repeat (3) @(negedge clk);
    check("acc_q_left", 32'(acc_q.size()), 0);
    check("idle_at_end", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
